// File: rtl/sparse_coord_pipe_if.sv
// Beat-level handshake bundle between the sparse index FIFOs, the coordinate
// pipe and the scatter/accumulator crossbar.
interface sparse_coord_pipe_if #(
  parameter int LANES  = 16,
  parameter int IDX_W  = 4,
  parameter int POS_W  = 16,
  parameter int WDIM_W = 4,
  parameter int ADIM_W = 9
);
  localparam int CNT_W = $clog2(LANES) + 1;

  logic                         in_valid;
  logic                         in_ready;
  logic                         tile_start;
  logic [1:0]                   mode;
  logic [CNT_W-1:0]             w_count;
  logic [CNT_W-1:0]             a_count;
  logic [LANES*IDX_W-1:0]       w_delta;
  logic [LANES*IDX_W-1:0]       a_delta;
  logic [WDIM_W-1:0]            weight_dim;
  logic [ADIM_W-1:0]            activation_dim;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES*LANES*POS_W-1:0] out_row;
  logic [LANES*LANES*POS_W-1:0] out_col;
  logic [LANES*LANES-1:0]       out_mask;
  logic                         out_err;

  modport master (
    output in_valid, tile_start, mode, w_count, a_count, w_delta, a_delta,
           weight_dim, activation_dim, out_ready,
    input  in_ready, out_valid, out_row, out_col, out_mask, out_err
  );

  modport slave (
    input  in_valid, tile_start, mode, w_count, a_count, w_delta, a_delta,
           weight_dim, activation_dim, out_ready,
    output in_ready, out_valid, out_row, out_col, out_mask, out_err
  );
endinterface

// File: rtl/sparse_coord_pipe.sv
// Two-stage pipe: rebuilds absolute sparse indices from zero-run deltas, then
// maps every weight x activation pair to its output-plane (row, col) and mask.
module sparse_coord_pipe #(
  parameter int LANES  = 16,
  parameter int IDX_W  = 4,
  parameter int ACC_W  = 16,
  parameter int POS_W  = 16,
  parameter int WDIM_W = 4,
  parameter int ADIM_W = 9
) (
  input logic               clk,
  input logic               reset_n,
  sparse_coord_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(LANES) + 1;
  localparam int LG    = $clog2(LANES);
  localparam int NP    = LANES * LANES;
  localparam int CW    = ACC_W + 2;

  function automatic logic signed [CW-1:0] plane_coord(
    input logic [WDIM_W-1:0] wdim,
    input logic [ACC_W-1:0]  wq,
    input logic [ACC_W-1:0]  aq
  );
    return $signed({{(CW-WDIM_W+1){1'b0}}, wdim[WDIM_W-1:1]})
         - $signed({2'b00, wq}) + $signed({2'b00, aq});
  endfunction

  function automatic logic in_plane(
    input logic signed [CW-1:0] v,
    input logic [ADIM_W-1:0]    dim
  );
    return (v >= 0) && (v < $signed({{(CW-ADIM_W){1'b0}}, dim}));
  endfunction

  logic             vld_p1, vld_p2;
  logic             s2_adv, accept;
  logic [ACC_W-1:0] w_base, a_base, w_base_nxt, a_base_nxt;
  logic [CNT_W-1:0] n_act, wcnt_c, acnt_c;
  logic             err_c;
  logic [ACC_W-1:0] w_idx_c [LANES];
  logic [ACC_W-1:0] a_idx_c [LANES];

  assign s2_adv       = !vld_p2 || bus.out_ready;
  assign bus.in_ready = !vld_p1 || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    case (bus.mode)
      2'd0:    n_act = CNT_W'(LANES);
      2'd1:    n_act = CNT_W'(LANES / 2);
      2'd2:    n_act = CNT_W'(LANES / 4);
      default: n_act = '0;
    endcase
    wcnt_c = (bus.w_count > n_act) ? n_act : bus.w_count;
    acnt_c = (bus.a_count > n_act) ? n_act : bus.a_count;
    err_c  = (bus.weight_dim == '0) || (bus.activation_dim == '0) || (bus.mode == 2'd3);
  end

  // Starting the chain at all-ones makes lane 0 of a new tile land on delta[0].
  always_comb begin
    logic [ACC_W-1:0] wp, ap;
    wp         = bus.tile_start ? '1 : w_base;
    ap         = bus.tile_start ? '1 : a_base;
    w_base_nxt = bus.tile_start ? '0 : w_base;
    a_base_nxt = bus.tile_start ? '0 : a_base;
    for (int k = 0; k < LANES; k++) begin
      wp = wp + ACC_W'(bus.w_delta[k*IDX_W +: IDX_W]) + ACC_W'(1);
      ap = ap + ACC_W'(bus.a_delta[k*IDX_W +: IDX_W]) + ACC_W'(1);
      w_idx_c[k] = wp;
      a_idx_c[k] = ap;
      if (k < int'(wcnt_c)) w_base_nxt = wp;
      if (k < int'(acnt_c)) a_base_nxt = ap;
    end
  end

  // ---- stage 1: absolute indices, clamped counts, beat attributes ----
  logic [ACC_W-1:0]  w_idx_p1 [LANES];
  logic [ACC_W-1:0]  a_idx_p1 [LANES];
  logic [CNT_W-1:0]  wcnt_p1, acnt_p1;
  logic [1:0]        mode_p1;
  logic              err_p1;
  logic [WDIM_W-1:0] wdim_p1;
  logic [ADIM_W-1:0] adim_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      w_base <= '0;
      a_base <= '0;
    end else begin
      if (bus.in_ready) vld_p1 <= bus.in_valid;
      if (accept) begin
        w_base <= w_base_nxt;
        a_base <= a_base_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      w_idx_p1 <= w_idx_c;
      a_idx_p1 <= a_idx_c;
      wcnt_p1  <= wcnt_c;
      acnt_p1  <= acnt_c;
      mode_p1  <= bus.mode;
      err_p1   <= err_c;
      wdim_p1  <= bus.weight_dim;
      adim_p1  <= bus.activation_dim;
    end
  end

  // Error beats divide by 1 so zero dimensions never reach the dividers.
  logic [ACC_W-1:0] wdiv, adiv;
  logic [ACC_W-1:0] wq_c [LANES];
  logic [ACC_W-1:0] wm_c [LANES];
  logic [ACC_W-1:0] aq_c [LANES];
  logic [ACC_W-1:0] am_c [LANES];

  always_comb begin
    wdiv = err_p1 ? ACC_W'(1) : ACC_W'(wdim_p1);
    adiv = err_p1 ? ACC_W'(1) : ACC_W'(adim_p1);
    for (int k = 0; k < LANES; k++) begin
      wq_c[k] = w_idx_p1[k] / wdiv;
      wm_c[k] = w_idx_p1[k] % wdiv;
      aq_c[k] = a_idx_p1[k] / adiv;
      am_c[k] = a_idx_p1[k] % adiv;
    end
  end

  logic [NP*POS_W-1:0] row_c, col_c;
  logic [NP-1:0]       mask_c;

  // Products are packed densely as p = i*N + j for the active lane count N.
  always_comb begin
    int                    n, sh;
    logic [LG-1:0]         ii, jj;
    logic signed [CW-1:0]  r, c;
    row_c  = '0;
    col_c  = '0;
    mask_c = '0;
    ii     = '0;
    jj     = '0;
    r      = '0;
    c      = '0;
    case (mode_p1)
      2'd0:    begin n = LANES;     sh = LG;     end
      2'd1:    begin n = LANES / 2; sh = LG - 1; end
      2'd2:    begin n = LANES / 4; sh = LG - 2; end
      default: begin n = 0;         sh = 0;      end
    endcase
    for (int p = 0; p < NP; p++) begin
      if (!err_p1 && (p < n * n)) begin
        ii = LG'(p >> sh);
        jj = LG'(p) & LG'(n - 1);
        r  = plane_coord(wdim_p1, wq_c[ii], aq_c[jj]);
        c  = plane_coord(wdim_p1, wm_c[ii], am_c[jj]);
        row_c[p*POS_W +: POS_W] = POS_W'(r);
        col_c[p*POS_W +: POS_W] = POS_W'(c);
        mask_c[p] = ({1'b0, ii} < wcnt_p1) && ({1'b0, jj} < acnt_p1)
                 && in_plane(r, adim_p1) && in_plane(c, adim_p1);
      end
    end
  end

  // ---- stage 2: coordinates and mask presented to the crossbar ----
  logic [NP*POS_W-1:0] row_p2, col_p2;
  logic [NP-1:0]       mask_p2;
  logic                err_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2  <= 1'b0;
      row_p2  <= '0;
      col_p2  <= '0;
      mask_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        row_p2  <= row_c;
        col_p2  <= col_c;
        mask_p2 <= mask_c;
        err_p2  <= err_p1;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_row   = row_p2;
  assign bus.out_col   = col_p2;
  assign bus.out_mask  = mask_p2;
  assign bus.out_err   = err_p2;
endmodule

// File: tb/tb_sparse_coord_pipe.sv
// Directed and randomized bench for sparse_coord_pipe against a plain
// arithmetic model of index reconstruction and coordinate mapping.
module tb_sparse_coord_pipe;
  localparam int LANES  = 16;
  localparam int IDX_W  = 4;
  localparam int ACC_W  = 16;
  localparam int POS_W  = 16;
  localparam int WDIM_W = 4;
  localparam int ADIM_W = 9;
  localparam int NP     = LANES * LANES;
  localparam int CNT_W  = $clog2(LANES) + 1;
  localparam int AMOD   = 1 << ACC_W;

  typedef struct {
    logic [NP*POS_W-1:0] row;
    logic [NP*POS_W-1:0] col;
    logic [NP*POS_W-1:0] care;
    logic [NP-1:0]       mask;
    logic                err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sparse_coord_pipe_if #(.LANES(LANES), .IDX_W(IDX_W), .POS_W(POS_W),
                         .WDIM_W(WDIM_W), .ADIM_W(ADIM_W)) bus ();

  sparse_coord_pipe #(.LANES(LANES), .IDX_W(IDX_W), .ACC_W(ACC_W), .POS_W(POS_W),
                      .WDIM_W(WDIM_W), .ADIM_W(ADIM_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  exp_t q[$];
  int   w_last = 0;
  int   a_last = 0;
  logic rand_done;
  logic [NP*POS_W-1:0] all_care;

  task automatic check(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic check_plane(input string tag, input logic [NP*POS_W-1:0] obs,
                             input logic [NP*POS_W-1:0] exp, input logic [NP*POS_W-1:0] care);
    logic [NP*POS_W-1:0] diff;
    int bad;
    checks++;
    diff = (obs ^ exp) & care;
    bad  = 0;
    assert ((obs & care) === (exp & care)) passes++;
    else begin
      fails++;
      for (int p = NP - 1; p >= 0; p--)
        if (diff[p*POS_W +: POS_W] !== '0) bad = p;
      $error("FAIL %s: product %0d got %0d required %0d", tag, bad,
             $signed(obs[bad*POS_W +: POS_W]), $signed(exp[bad*POS_W +: POS_W]));
    end
  endtask

  // Reference: indices from the delta rules, coordinates with integer / and %.
  task automatic model_accept(input logic ts, input logic [1:0] md, input int wc, input int ac,
                              input logic [LANES*IDX_W-1:0] wd, input logic [LANES*IDX_W-1:0] ad,
                              input int wdim, input int adim);
    exp_t e;
    int n, wcl, acl, r, c, p, d;
    int wi[LANES];
    int ai[LANES];
    n   = (md == 2'd0) ? LANES : (md == 2'd1) ? LANES / 2 : (md == 2'd2) ? LANES / 4 : 0;
    wcl = (wc > n) ? n : wc;
    acl = (ac > n) ? n : ac;
    for (int k = 0; k < wcl; k++) begin
      d = int'(wd[k*IDX_W +: IDX_W]);
      if (k == 0) wi[k] = ts ? d : (w_last + d + 1) % AMOD;
      else        wi[k] = (wi[k-1] + d + 1) % AMOD;
    end
    for (int k = 0; k < acl; k++) begin
      d = int'(ad[k*IDX_W +: IDX_W]);
      if (k == 0) ai[k] = ts ? d : (a_last + d + 1) % AMOD;
      else        ai[k] = (ai[k-1] + d + 1) % AMOD;
    end
    e.row  = '0;
    e.col  = '0;
    e.care = '1;
    e.mask = '0;
    e.err  = (wdim == 0) || (adim == 0) || (md == 2'd3);
    if (!e.err) begin
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < n; j++) begin
          p = i * n + j;
          if (i < wcl && j < acl) begin
            r = wdim / 2 - wi[i] / wdim + ai[j] / adim;
            c = wdim / 2 - wi[i] % wdim + ai[j] % adim;
            e.row[p*POS_W +: POS_W] = POS_W'(r);
            e.col[p*POS_W +: POS_W] = POS_W'(c);
            e.mask[p] = (r >= 0) && (r < adim) && (c >= 0) && (c < adim);
          end else begin
            e.care[p*POS_W +: POS_W] = '0;
          end
        end
      end
    end
    q.push_back(e);
    if (wcl > 0) w_last = wi[wcl-1]; else if (ts) w_last = 0;
    if (acl > 0) a_last = ai[acl-1]; else if (ts) a_last = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic offer(input logic ts, input logic [1:0] md, input int wc, input int ac,
                       input logic [LANES*IDX_W-1:0] wd, input logic [LANES*IDX_W-1:0] ad,
                       input int wdim, input int adim);
    int guard;
    bus.tile_start     = ts;
    bus.mode           = md;
    bus.w_count        = CNT_W'(wc);
    bus.a_count        = CNT_W'(ac);
    bus.w_delta        = wd;
    bus.a_delta        = ad;
    bus.weight_dim     = WDIM_W'(wdim);
    bus.activation_dim = ADIM_W'(adim);
    bus.in_valid       = 1'b1;
    guard = 0;
    #1;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("in_ready_for_beat", NP'(bus.in_ready), NP'(1));
    if (bus.in_ready === 1'b1) begin
      @(posedge clk);
      model_accept(ts, md, wc, ac, wd, ad, wdim, adim);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (reset_n === 1'b1 && bus.out_valid === 1'b1) begin
      check("valid_has_expected_beat", NP'(q.size() > 0), NP'(1));
      if (q.size() > 0) begin
        check("out_err", NP'(bus.out_err), NP'(q[0].err));
        check("out_mask", bus.out_mask, q[0].mask);
        check_plane("out_row", bus.out_row, q[0].row, q[0].care);
        check_plane("out_col", bus.out_col, q[0].col, q[0].care);
        if (bus.out_ready === 1'b1) void'(q.pop_front());
      end
    end
  end

  initial begin
    int v, n, wc, ac, guard;
    logic [LANES*IDX_W-1:0] wd, ad;
    all_care           = '1;
    rand_done          = 1'b0;
    reset_n            = 1'b0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b1;
    bus.tile_start     = 1'b0;
    bus.mode           = 2'd0;
    bus.w_count        = '0;
    bus.a_count        = '0;
    bus.w_delta        = '0;
    bus.a_delta        = '0;
    bus.weight_dim     = '0;
    bus.activation_dim = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", NP'(bus.out_valid), NP'(0));
    check("reset_out_err", NP'(bus.out_err), NP'(0));
    check("reset_out_mask", bus.out_mask, '0);
    check_plane("reset_out_row", bus.out_row, '0, all_care);
    check_plane("reset_out_col", bus.out_col, '0, all_care);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("in_ready_after_reset", NP'(bus.in_ready), NP'(1));
    @(negedge clk);

    // Basic mode-2 beat with exact latency and hand-derived coordinates.
    offer(1'b1, 2'd2, 4, 4, 64'h0, 64'h10, 3, 8);
    #1;
    check("latency_not_early", NP'(bus.out_valid), NP'(0));
    @(negedge clk);
    #1;
    check("latency_two_cycles", NP'(bus.out_valid), NP'(1));
    v = $signed(bus.out_row[0*POS_W +: POS_W]);  check("p0_row", NP'(v), NP'(1));
    v = $signed(bus.out_col[0*POS_W +: POS_W]);  check("p0_col", NP'(v), NP'(1));
    check("p0_mask", NP'(bus.out_mask[0]), NP'(1));
    v = $signed(bus.out_row[15*POS_W +: POS_W]); check("p15_row", NP'(v), NP'(0));
    v = $signed(bus.out_col[15*POS_W +: POS_W]); check("p15_col", NP'(v), NP'(5));
    check("p15_mask", NP'(bus.out_mask[15]), NP'(1));
    v = $signed(bus.out_col[8*POS_W +: POS_W]);  check("p8_col", NP'(v), NP'(-1));
    check("p8_mask", NP'(bus.out_mask[8]), NP'(0));
    @(negedge clk);

    // Continuation, then tile restart.
    offer(1'b0, 2'd2, 4, 4, 64'h1, 64'h0, 3, 8);
    offer(1'b1, 2'd2, 4, 4, 64'h2, 64'h0, 3, 8);

    // Partial mode-0 beat, then a continuation from its last valid lanes.
    offer(1'b1, 2'd0, 3, 5, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 5, 16);
    offer(1'b0, 2'd0, 2, 2, 64'h0000_0000_0000_0031, 64'h0000_0000_0000_0002, 5, 16);

    // Backpressure: consumer stalls for five cycles while four beats stream in.
    bus.out_ready = 1'b0;
    fork
      begin
        offer(1'b1, 2'd1, 8, 8, 64'h1111_2222_3333_4444, 64'h0102_0304_0506_0708, 7, 20);
        offer(1'b0, 2'd1, 6, 7, 64'h0, 64'h5, 7, 20);
        offer(1'b0, 2'd2, 4, 3, 64'h3, 64'h0, 4, 12);
        offer(1'b1, 2'd0, 16, 16, 64'hffff_0000_ffff_0000, 64'h0f0f_0f0f_0f0f_0f0f, 9, 30);
      end
      begin
        repeat (2) @(negedge clk);
        #1;
        check("in_ready_drops_when_full", NP'(bus.in_ready), NP'(0));
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join

    // Error beats: zero weight_dim, then reserved mode.
    offer(1'b1, 2'd0, 4, 4, 64'h12, 64'h34, 0, 8);
    offer(1'b0, 2'd3, 4, 4, 64'h12, 64'h34, 3, 8);
    offer(1'b0, 2'd2, 4, 4, 64'h0, 64'h0, 3, 8);

    // Randomized traffic with a randomly stalling consumer.
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          logic [1:0] md;
          md = 2'($urandom_range(2, 0));
          n  = LANES >> md;
          wc = $urandom_range(n, 1);
          ac = $urandom_range(n, 1);
          wd = {$urandom, $urandom};
          ad = {$urandom, $urandom};
          offer(($urandom % 4) == 0 || b == 0, md, wc, ac, wd, ad,
                $urandom_range(15, 1), $urandom_range(40, 2));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          bus.out_ready = ($urandom % 3) != 0;
        end
      end
    join
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_random", NP'(q.size()), NP'(0));

    // Asynchronous reset with two beats in flight.
    offer(1'b1, 2'd2, 4, 4, 64'h5, 64'h7, 3, 8);
    offer(1'b0, 2'd2, 4, 4, 64'h1, 64'h1, 3, 8);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", NP'(bus.out_valid), NP'(0));
    check("async_reset_out_mask", bus.out_mask, '0);
    q.delete();
    w_last = 0;
    a_last = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    offer(1'b0, 2'd2, 4, 4, 64'h0000_0000_0000_0102, 64'h0000_0000_0000_0021, 3, 8);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_final", NP'(q.size()), NP'(0));
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
